// File: rtl/openofdm_rx_byte_packer.sv
// Frames OpenOFDM receiver output into 64-bit header/data/trailer words and
// streams them through a first-word-fall-through FIFO onto an AXI-Stream master.
module openofdm_rx_byte_packer #(
  parameter int FIFO_ADDR_WIDTH    = 6,
  parameter int RSSI_HALF_DB_WIDTH = 11
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          pkt_header_valid_strobe,
  input  logic                          pkt_header_valid,
  input  logic [7:0]                    pkt_rate,
  input  logic [15:0]                   pkt_len,
  input  logic                          ht_aggr,
  input  logic                          ht_aggr_last,
  input  logic                          ht_sgi,
  input  logic [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db,
  input  logic                          demod_is_ongoing,
  input  logic                          byte_out_strobe,
  input  logic [7:0]                    byte_out,
  input  logic                          fcs_out_strobe,
  input  logic                          fcs_ok,
  output logic [63:0]                   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [15:0]                   pkt_drop_count,
  output logic                          ovf_sticky
);

  localparam int AW    = FIFO_ADDR_WIDTH;
  localparam int CW    = FIFO_ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DATA    = 2'd1,
    S_FLUSH   = 2'd2,
    S_TRAILER = 2'd3
  } state_t;

  state_t      r_state, w_state_next;
  logic [15:0] r_byte_cnt, w_byte_cnt_next;
  logic [63:0] r_asm, w_asm_next;
  logic [15:0] r_pkt_len, w_pkt_len_next;
  logic        r_ovf_pkt, w_ovf_pkt_next;
  logic        r_abort, w_abort_next;
  logic        r_fcs_ok, w_fcs_ok_next;
  logic [15:0] r_drop_cnt, w_drop_cnt_next;
  logic        r_ovf_sticky, w_ovf_sticky_next;
  logic        r_demod_d;

  // One-deep holding slot for a header that arrives while a trailer is pending
  logic        r_hp_valid, w_hp_valid_next;
  logic [15:0] r_hp_len, w_hp_len_next;
  logic [7:0]  r_hp_rate, w_hp_rate_next;
  logic [2:0]  r_hp_flags, w_hp_flags_next;
  logic [15:0] r_hp_rssi, w_hp_rssi_next;

  logic        w_push;
  logic        w_push_last;
  logic [63:0] w_push_data;

  logic [64:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_mem_cnt;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic          r_out_last;
  logic [63:0]   r_out_data;

  logic          w_live_hdr;
  logic          w_take_hdr;
  logic          w_demod_fall;
  logic [2:0]    w_live_flags;
  logic [15:0]   w_rssi_ext;
  logic [63:0]   w_hdr_word;
  logic [15:0]   w_hdr_len;
  logic [63:0]   w_trl_word;
  logic [63:0]   w_asm_fill;
  logic [15:0]   w_cnt_inc;
  logic [CW-1:0] w_free;
  logic          w_room;
  logic          w_lane7;
  logic          w_pkt_end;

  logic          w_pop_out;
  logic          w_load;
  logic          w_mem_empty;
  logic          w_bypass;
  logic          w_mem_wr;
  logic          w_mem_rd;

  assign w_live_hdr   = pkt_header_valid_strobe & pkt_header_valid;
  assign w_take_hdr   = w_live_hdr | r_hp_valid;
  assign w_demod_fall = r_demod_d & ~demod_is_ongoing;
  assign w_live_flags = {ht_sgi, ht_aggr_last, ht_aggr};
  assign w_rssi_ext   = 16'($signed(rssi_half_db));

  assign w_hdr_word = r_hp_valid
    ? {r_hp_len, r_hp_rate, r_hp_flags, 5'd0, r_hp_rssi, 16'hA55A}
    : {pkt_len, pkt_rate, w_live_flags, 5'd0, w_rssi_ext, 16'hA55A};
  assign w_hdr_len  = r_hp_valid ? r_hp_len : pkt_len;
  assign w_trl_word = {r_fcs_ok, r_ovf_pkt, r_abort, 13'd0, r_byte_cnt, r_pkt_len, 16'h5AA5};

  // Keep one slot back so the trailer can always be written
  assign w_free = CW'(DEPTH) - r_count;
  assign w_room = (w_free >= CW'(2));

  assign w_cnt_inc = r_byte_cnt + {15'd0, byte_out_strobe};
  assign w_lane7   = byte_out_strobe & (r_byte_cnt[2:0] == 3'd7);
  assign w_pkt_end = fcs_out_strobe | w_demod_fall | w_live_hdr;

  always_comb begin
    w_asm_fill = r_asm;
    if (byte_out_strobe) begin
      w_asm_fill[{r_byte_cnt[2:0], 3'b000} +: 8] = byte_out;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_byte_cnt_next   = r_byte_cnt;
    w_asm_next        = r_asm;
    w_pkt_len_next    = r_pkt_len;
    w_ovf_pkt_next    = r_ovf_pkt;
    w_abort_next      = r_abort;
    w_fcs_ok_next     = r_fcs_ok;
    w_drop_cnt_next   = r_drop_cnt;
    w_ovf_sticky_next = r_ovf_sticky;
    w_hp_valid_next   = r_hp_valid;
    w_hp_len_next     = r_hp_len;
    w_hp_rate_next    = r_hp_rate;
    w_hp_flags_next   = r_hp_flags;
    w_hp_rssi_next    = r_hp_rssi;
    w_push            = 1'b0;
    w_push_last       = 1'b0;
    w_push_data       = 64'd0;

    case (r_state)
      S_IDLE: begin
        if (w_take_hdr) begin
          w_hp_valid_next = 1'b0;
          if (w_room) begin
            w_push          = 1'b1;
            w_push_data     = w_hdr_word;
            w_byte_cnt_next = 16'd0;
            w_asm_next      = 64'd0;
            w_pkt_len_next  = w_hdr_len;
            w_ovf_pkt_next  = 1'b0;
            w_abort_next    = 1'b0;
            w_fcs_ok_next   = 1'b0;
            w_state_next    = S_DATA;
          end else if (r_drop_cnt != 16'hFFFF) begin
            w_drop_cnt_next = r_drop_cnt + 16'd1;
          end
        end
      end

      S_DATA: begin
        w_asm_next      = w_asm_fill;
        w_byte_cnt_next = w_cnt_inc;
        if (w_lane7) begin
          w_asm_next = 64'd0;
          if (w_room) begin
            w_push      = 1'b1;
            w_push_data = w_asm_fill;
          end else begin
            w_ovf_pkt_next    = 1'b1;
            w_ovf_sticky_next = 1'b1;
          end
        end
        if (w_pkt_end) begin
          w_abort_next  = ~fcs_out_strobe;
          w_fcs_ok_next = fcs_out_strobe & fcs_ok;
          w_state_next  = (w_cnt_inc[2:0] != 3'd0) ? S_FLUSH : S_TRAILER;
        end
      end

      S_FLUSH: begin
        if (w_room) begin
          w_push      = 1'b1;
          w_push_data = r_asm;
        end else begin
          w_ovf_pkt_next    = 1'b1;
          w_ovf_sticky_next = 1'b1;
        end
        w_state_next = S_TRAILER;
      end

      default: begin
        w_push       = 1'b1;
        w_push_last  = 1'b1;
        w_push_data  = w_trl_word;
        w_state_next = S_IDLE;
      end
    endcase

    if ((r_state == S_FLUSH || r_state == S_TRAILER) && w_live_hdr) begin
      w_hp_valid_next = 1'b1;
      w_hp_len_next   = pkt_len;
      w_hp_rate_next  = pkt_rate;
      w_hp_flags_next = w_live_flags;
      w_hp_rssi_next  = w_rssi_ext;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_byte_cnt   <= 16'd0;
      r_asm        <= 64'd0;
      r_pkt_len    <= 16'd0;
      r_ovf_pkt    <= 1'b0;
      r_abort      <= 1'b0;
      r_fcs_ok     <= 1'b0;
      r_drop_cnt   <= 16'd0;
      r_ovf_sticky <= 1'b0;
      r_demod_d    <= 1'b0;
      r_hp_valid   <= 1'b0;
      r_hp_len     <= 16'd0;
      r_hp_rate    <= 8'd0;
      r_hp_flags   <= 3'd0;
      r_hp_rssi    <= 16'd0;
    end else begin
      r_state      <= w_state_next;
      r_byte_cnt   <= w_byte_cnt_next;
      r_asm        <= w_asm_next;
      r_pkt_len    <= w_pkt_len_next;
      r_ovf_pkt    <= w_ovf_pkt_next;
      r_abort      <= w_abort_next;
      r_fcs_ok     <= w_fcs_ok_next;
      r_drop_cnt   <= w_drop_cnt_next;
      r_ovf_sticky <= w_ovf_sticky_next;
      r_demod_d    <= demod_is_ongoing;
      r_hp_valid   <= w_hp_valid_next;
      r_hp_len     <= w_hp_len_next;
      r_hp_rate    <= w_hp_rate_next;
      r_hp_flags   <= w_hp_flags_next;
      r_hp_rssi    <= w_hp_rssi_next;
    end
  end

  // Output register is part of the storage: r_count covers memory plus it.
  // An empty memory lets a push go straight into the output register.
  assign w_pop_out   = r_out_valid & m_axis_tready;
  assign w_load      = ~r_out_valid | m_axis_tready;
  assign w_mem_empty = (r_mem_cnt == CW'(0));
  assign w_bypass    = w_push & w_load & w_mem_empty;
  assign w_mem_wr    = w_push & ~w_bypass;
  assign w_mem_rd    = w_load & ~w_mem_empty;

  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      r_mem[r_wr_ptr] <= {w_push_last, w_push_data};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_cnt   <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= 64'd0;
    end else begin
      if (w_mem_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_mem_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_mem_cnt <= r_mem_cnt + {{(CW-1){1'b0}}, w_mem_wr} - {{(CW-1){1'b0}}, w_mem_rd};
      r_count   <= r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop_out};
      if (w_mem_rd) begin
        {r_out_last, r_out_data} <= r_mem[r_rd_ptr];
        r_out_valid              <= 1'b1;
      end else if (w_bypass) begin
        r_out_last  <= w_push_last;
        r_out_data  <= w_push_data;
        r_out_valid <= 1'b1;
      end else if (w_pop_out) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata   = r_out_data;
  assign m_axis_tvalid  = r_out_valid;
  assign m_axis_tlast   = r_out_last;
  assign pkt_drop_count = r_drop_cnt;
  assign ovf_sticky     = r_ovf_sticky;

endmodule

// File: tb/tb_openofdm_rx_byte_packer.sv
// Scoreboard bench for openofdm_rx_byte_packer: a packet-level model queues the
// expected words, a forked monitor compares every AXI-Stream transfer.
module tb_openofdm_rx_byte_packer;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int RW    = 11;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          pkt_header_valid_strobe = 1'b0;
  logic          pkt_header_valid = 1'b0;
  logic [7:0]    pkt_rate = 8'd0;
  logic [15:0]   pkt_len = 16'd0;
  logic          ht_aggr = 1'b0;
  logic          ht_aggr_last = 1'b0;
  logic          ht_sgi = 1'b0;
  logic [RW-1:0] rssi_half_db = '0;
  logic          demod_is_ongoing = 1'b0;
  logic          byte_out_strobe = 1'b0;
  logic [7:0]    byte_out = 8'd0;
  logic          fcs_out_strobe = 1'b0;
  logic          fcs_ok = 1'b0;
  logic [63:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic [15:0]   pkt_drop_count;
  logic          ovf_sticky;

  int errors = 0;
  int checks = 0;
  int tready_mode = 0;
  int low_run = 0;
  logic [64:0] sb_q[$];
  logic [7:0]  pkt_bytes[$];

  always #5 clk = ~clk;

  openofdm_rx_byte_packer #(
    .FIFO_ADDR_WIDTH(AW),
    .RSSI_HALF_DB_WIDTH(RW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .pkt_header_valid_strobe(pkt_header_valid_strobe),
    .pkt_header_valid(pkt_header_valid),
    .pkt_rate(pkt_rate),
    .pkt_len(pkt_len),
    .ht_aggr(ht_aggr),
    .ht_aggr_last(ht_aggr_last),
    .ht_sgi(ht_sgi),
    .rssi_half_db(rssi_half_db),
    .demod_is_ongoing(demod_is_ongoing),
    .byte_out_strobe(byte_out_strobe),
    .byte_out(byte_out),
    .fcs_out_strobe(fcs_out_strobe),
    .fcs_ok(fcs_ok),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .pkt_drop_count(pkt_drop_count),
    .ovf_sticky(ovf_sticky)
  );

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h required 0x%016h", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (rstn && m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got last=%0b data=0x%016h required no word",
                   m_axis_tlast, m_axis_tdata);
        end else begin
          e = sb_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e) begin
            errors++;
            $display("FAIL axis_word: got last=%0b data=0x%016h required last=%0b data=0x%016h",
                     m_axis_tlast, m_axis_tdata, e[64], e[63:0]);
          end else begin
            $display("word last=%0b data=0x%016h ok", m_axis_tlast, m_axis_tdata);
          end
        end
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    pkt_header_valid_strobe = 1'b0;
    byte_out_strobe         = 1'b0;
    fcs_out_strobe          = 1'b0;
    case (tready_mode)
      0: m_axis_tready = 1'b0;
      1: m_axis_tready = 1'b1;
      default: begin
        if (low_run >= 3) m_axis_tready = 1'b1;
        else m_axis_tready = 1'($urandom_range(0, 1));
        low_run = m_axis_tready ? 0 : low_run + 1;
      end
    endcase
  endtask

  // Packet-level model: header, little-endian data words (at most cap of them
  // fit), trailer carrying status and the received byte count.
  task automatic model_pkt(input logic [15:0] len, input logic [7:0] rate, input logic [2:0] flags,
                           input logic [RW-1:0] rssi, input bit fcs, input bit abort, input int cap);
    logic [63:0] w;
    logic [15:0] rssi16;
    int n, nwords;
    rssi16 = {{(16-RW){rssi[RW-1]}}, rssi};
    sb_q.push_back({1'b0, len, rate, flags, 5'd0, rssi16, 16'hA55A});
    n = pkt_bytes.size();
    nwords = (n + 7) / 8;
    for (int wi = 0; wi < nwords; wi++) begin
      w = 64'd0;
      for (int k = 0; k < 8; k++) begin
        if (wi * 8 + k < n) w[8*k +: 8] = pkt_bytes[wi * 8 + k];
      end
      if (wi < cap) sb_q.push_back({1'b0, w});
    end
    sb_q.push_back({1'b1, fcs, (nwords > cap), abort, 13'd0, 16'(n), len, 16'h5AA5});
  endtask

  // endmode: 0 FCS strobe, 1 demod falls, 2 new header aborts, 3 stop mid-packet
  task automatic send_pkt(input int len, input int n, input bit fcs, input int endmode,
                          input int cap, input bit inc, input bit expect_words);
    logic [7:0] rate;
    logic [2:0] flags;
    logic [RW-1:0] rssi;
    bit together;
    rate  = 8'($urandom);
    flags = 3'($urandom);
    rssi  = RW'($urandom);
    pkt_bytes.delete();
    for (int i = 0; i < n; i++) pkt_bytes.push_back(inc ? 8'(i) : 8'($urandom));
    if (expect_words)
      model_pkt(16'(len), rate, flags, rssi, (endmode == 0) ? fcs : 1'b0, (endmode != 0), cap);
    next_cycle();
    pkt_header_valid_strobe = 1'b1;
    pkt_header_valid        = 1'b1;
    pkt_len                 = 16'(len);
    pkt_rate                = rate;
    {ht_sgi, ht_aggr_last, ht_aggr} = flags;
    rssi_half_db            = rssi;
    demod_is_ongoing        = 1'b1;
    together = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) next_cycle();
      next_cycle();
      byte_out_strobe = 1'b1;
      byte_out        = pkt_bytes[i];
      if (i == n - 1 && endmode == 0 && $urandom_range(0, 1) == 1) begin
        fcs_out_strobe = 1'b1;
        fcs_ok         = fcs;
        together       = 1'b1;
      end
    end
    case (endmode)
      0: if (!together) begin
        next_cycle();
        fcs_out_strobe = 1'b1;
        fcs_ok         = fcs;
      end
      1: begin
        next_cycle();
        demod_is_ongoing = 1'b0;
      end
      2: begin
        next_cycle();
        pkt_header_valid_strobe = 1'b1;
        pkt_header_valid        = 1'b1;
        pkt_len                 = 16'($urandom);
      end
      default: ;
    endcase
    if (endmode != 3) begin
      next_cycle();
      demod_is_ongoing = 1'b0;
      repeat (4) next_cycle();
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 3000) begin
      next_cycle();
      t++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d words outstanding required 0", name, sb_q.size());
    end
    repeat (3) next_cycle();
  endtask

  initial begin
    int r, em, len, n;
    fork
      monitor_loop();
    join_none

    #3 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_val("rst_tdata", m_axis_tdata, 64'd0);
    check_val("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check_val("rst_drop", 64'(pkt_drop_count), 64'd0);
    check_val("rst_ovf", 64'(ovf_sticky), 64'd0);
    rstn = 1'b1;
    next_cycle();

    tready_mode = 1;
    send_pkt(16, 16, 1'b1, 0, 1000, 1'b1, 1'b1);
    drain("good16");
    send_pkt(13, 13, 1'b0, 0, 1000, 1'b1, 1'b1);
    drain("len13");
    send_pkt(20, 5, 1'b1, 1, 1000, 1'b1, 1'b1);
    drain("demod_fall");
    send_pkt(24, 11, 1'b1, 2, 1000, 1'b0, 1'b1);
    drain("hdr_abort");

    tready_mode = 0;
    next_cycle();
    pkt_header_valid_strobe = 1'b1;
    pkt_header_valid        = 1'b0;
    repeat (4) next_cycle();
    check_val("invalid_hdr_tvalid", 64'(m_axis_tvalid), 64'd0);

    send_pkt(100, 100, 1'b1, 0, DEPTH - 2, 1'b1, 1'b1);
    check_val("ovf_sticky", 64'(ovf_sticky), 64'd1);
    next_cycle();
    pkt_header_valid_strobe = 1'b1;
    pkt_header_valid        = 1'b1;
    repeat (3) next_cycle();
    check_val("full_drop_count", 64'(pkt_drop_count), 64'd1);
    tready_mode = 1;
    drain("overflow");
    check_val("overflow_empty_tvalid", 64'(m_axis_tvalid), 64'd0);

    tready_mode = 2;
    for (int p = 0; p < 30; p++) begin
      len = int'($urandom_range(0, 40));
      r   = int'($urandom_range(0, 9));
      em  = (r < 6) ? 0 : (r < 8) ? 1 : 2;
      n   = (em == 0) ? len : int'($urandom_range(0, len));
      send_pkt(len, n, 1'($urandom), em, 1000, 1'b0, 1'b1);
    end
    drain("random");
    check_val("random_drop_count", 64'(pkt_drop_count), 64'd1);

    tready_mode = 0;
    next_cycle();
    send_pkt(30, 10, 1'b1, 3, 1000, 1'b0, 1'b0);
    next_cycle();
    check_val("prereset_tvalid", 64'(m_axis_tvalid), 64'd1);
    rstn = 1'b0;
    #2;
    check_val("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_val("midrst_drop", 64'(pkt_drop_count), 64'd0);
    check_val("midrst_ovf", 64'(ovf_sticky), 64'd0);
    demod_is_ongoing = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    tready_mode = 1;
    repeat (5) next_cycle();
    check_val("postrst_tvalid", 64'(m_axis_tvalid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
